// File: rtl/oled_pkg.sv
// Shared constants, state encoding and address helper for the OLED frame buffer.
package oled_pkg;

   localparam int FRAME_BYTES = 1024;
   localparam int ADDR_W      = 10;
   localparam int MEM_AW      = ADDR_W + 1;
   localparam int DATA_W      = 8;

   localparam logic [ADDR_W-1:0] LAST_ADDR = 10'd1023;
   localparam logic [MEM_AW-1:0] FILL_LAST = 11'd2047;
   localparam logic [ADDR_W-1:0] PTR_ONE   = 10'd1;
   localparam logic [MEM_AW-1:0] FILL_ONE  = 11'd1;

   typedef enum logic [1:0] {
      INIT_FILL,
      LOAD,
      CLEAR,
      WAIT_SWAP
   } state_t;

   // Physical memory address: bank select on top of the in-frame offset.
   function automatic logic [MEM_AW-1:0] bank_addr(input logic bank,
                                                   input logic [ADDR_W-1:0] offset);
      return {bank, offset};
   endfunction

endpackage

// File: rtl/oled_frame_ram.sv
// Simple dual-port 2048x8 frame store: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module oled_frame_ram
   import oled_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [MEM_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [MEM_AW-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 * FRAME_BYTES;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   // Write port: one byte per cycle when enabled.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port: data appears one cycle after the address.
   always_ff @(posedge clk) begin
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/oled_frame_buffer.sv
// Double-buffered 1024-byte OLED frame store. The producer fills the back bank,
// the display driver scans the front bank, and banks swap only on the driver's
// 1023 -> 0 address wrap so a frame is never shown half-updated.
module oled_frame_buffer
   import oled_pkg::*;
#(
   parameter logic RESET_FILL = 1'b1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_value,
   input  logic [ADDR_W-1:0] pixel_address,
   output logic [DATA_W-1:0] pixel_data,
   output logic              busy,
   output logic              frame_swapped
);

   state_t            r_state;
   logic [MEM_AW-1:0] r_fill_cnt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_prev_addr;
   logic              r_front;
   logic              r_swapped;
   logic              r_force_zero;
   logic [DATA_W-1:0] r_clear_val;

   logic              w_wrap;
   logic              w_swap;
   logic              w_accept;
   logic              w_we;
   logic [MEM_AW-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [MEM_AW-1:0] w_raddr;
   logic [DATA_W-1:0] w_rdata;

   // The driver has finished a full scan when its address steps 1023 -> 0.
   assign w_wrap   = (r_prev_addr == LAST_ADDR) && (pixel_address == '0);
   // Only a completed back frame turns a wrap into a bank swap.
   assign w_swap   = w_wrap && (r_state == WAIT_SWAP);

   // Ready depends only on state and clear_req, never on in_valid.
   assign in_ready = (r_state == LOAD) && !clear_req;
   assign w_accept = in_valid && in_ready;
   assign busy     = (r_state != LOAD);

   // The read issued in the wrap cycle already targets the new front bank.
   assign w_raddr  = bank_addr(r_front ^ w_swap, pixel_address);

   // Write-port mux: zero fill, producer bytes, or clear pattern into the back bank.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = bank_addr(~r_front, r_wr_ptr);
      w_wdata = in_data;
      if (rst_n) begin
         case (r_state)
            INIT_FILL: begin
               w_we    = 1'b1;
               w_waddr = r_fill_cnt;
               w_wdata = '0;
            end
            LOAD: begin
               w_we    = w_accept;
            end
            CLEAR: begin
               w_we    = 1'b1;
               w_wdata = r_clear_val;
            end
            default: begin
               w_we    = 1'b0;
            end
         endcase
      end
   end

   // Main control FSM: fill, load, clear and swap sequencing with registered swap pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RESET_FILL ? INIT_FILL : LOAD;
         r_fill_cnt  <= '0;
         r_wr_ptr    <= '0;
         r_front     <= 1'b0;
         r_swapped   <= 1'b0;
         r_clear_val <= '0;
      end else begin
         r_swapped <= 1'b0;
         case (r_state)
            INIT_FILL: begin
               // Counter rolls back to zero on its own after the last location.
               r_fill_cnt <= r_fill_cnt + FILL_ONE;
               if (r_fill_cnt == FILL_LAST) begin
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               if (clear_req) begin
                  // A clear discards any partially loaded frame.
                  r_state     <= CLEAR;
                  r_wr_ptr    <= '0;
                  r_clear_val <= clear_value;
               end else if (in_valid) begin
                  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                  if (r_wr_ptr == LAST_ADDR) begin
                     r_state <= WAIT_SWAP;
                  end
               end
            end
            CLEAR: begin
               r_wr_ptr <= r_wr_ptr + PTR_ONE;
               if (r_wr_ptr == LAST_ADDR) begin
                  r_state <= WAIT_SWAP;
               end
            end
            WAIT_SWAP: begin
               if (w_wrap) begin
                  r_front   <= ~r_front;
                  r_swapped <= 1'b1;
                  r_state   <= LOAD;
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

   // Track the previous driver address for wrap detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_addr <= '0;
      end else begin
         r_prev_addr <= pixel_address;
      end
   end

   // Blank the output after reset and for every read issued during the initial fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_force_zero <= 1'b1;
      end else begin
         r_force_zero <= (r_state == INIT_FILL);
      end
   end

   oled_frame_ram u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign pixel_data    = r_force_zero ? '0 : w_rdata;
   assign frame_swapped = r_swapped;

endmodule

// File: tb/tb_oled_frame_buffer.sv
// Scoreboard bench for oled_frame_buffer: a frame-level reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares on every cycle.
module tb_oled_frame_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_b_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       clear_req;
   logic [7:0] clear_value;
   logic [9:0] pixel_address = '0;

   logic       in_ready,   busy,   frame_swapped;
   logic [7:0] pixel_data;
   logic       in_ready_b, busy_b, frame_swapped_b;
   logic [7:0] pixel_data_b;

   always #5 clk = ~clk;

   oled_frame_buffer #(.RESET_FILL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .clear_req(clear_req), .clear_value(clear_value),
      .pixel_address(pixel_address), .pixel_data(pixel_data), .busy(busy),
      .frame_swapped(frame_swapped)
   );

   // Second instance without the reset fill, sharing all inputs except reset.
   oled_frame_buffer #(.RESET_FILL(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_b), .clear_req(clear_req), .clear_value(clear_value),
      .pixel_address(pixel_address), .pixel_data(pixel_data_b), .busy(busy_b),
      .frame_swapped(frame_swapped_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] pix;
      logic       swp;
      logic       bsy;
      logic       idle;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_mem [2][1024];
   int         m_front;
   int         m_init_left;
   int         m_clear_left;
   int         m_loaded;
   bit         m_frame_ready;
   logic [7:0] m_clear_val;
   int         m_prev;

   always @(posedge clk) begin : p_model
      exp_t e;
      bit   wrap;
      bit   swap;
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int a = 0; a < 1024; a++) m_mem[b][a] = 8'h00;
         m_front = 0; m_init_left = 2048; m_clear_left = 0;
         m_loaded = 0; m_frame_ready = 0; m_prev = 0;
         e = '{8'h00, 1'b0, 1'b1, 1'b0};
      end else begin
         wrap  = (m_prev == 1023) && (pixel_address == 10'd0);
         swap  = wrap && m_frame_ready;
         e.pix = (m_init_left > 0) ? 8'h00 : m_mem[m_front ^ int'(swap)][pixel_address];
         e.swp = swap;
         if (m_init_left > 0) begin
            m_init_left--;
         end else if (m_clear_left > 0) begin
            m_mem[1 - m_front][1024 - m_clear_left] = m_clear_val;
            m_clear_left--;
            if (m_clear_left == 0) m_frame_ready = 1;
         end else if (m_frame_ready) begin
            if (wrap) begin
               m_front       = 1 - m_front;
               m_frame_ready = 0;
            end
         end else if (clear_req) begin
            m_clear_left = 1024;
            m_clear_val  = clear_value;
            m_loaded     = 0;
         end else if (in_valid) begin
            m_mem[1 - m_front][m_loaded] = in_data;
            m_loaded++;
            if (m_loaded == 1024) begin
               m_loaded      = 0;
               m_frame_ready = 1;
            end
         end
         m_prev = int'(pixel_address);
         e.bsy  = (m_init_left > 0) || (m_clear_left > 0) || m_frame_ready;
         e.idle = !e.bsy;
      end
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   int swap_cnt = 0;
   int hs_cnt   = 0;

   always @(negedge clk) begin : p_monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pixel_data",    pixel_data,    e.pix);
         chk("frame_swapped", frame_swapped, e.swp);
         chk("busy",          busy,          e.bsy);
         chk("in_ready",      in_ready,      e.idle && !clear_req);
      end
      if (frame_swapped === 1'b1) swap_cnt++;
      if (in_valid && in_ready) hs_cnt++;
   end

   // ---------------- address driver ----------------
   bit         sweep    = 1'b1;
   logic [9:0] hold_addr = '0;

   always @(posedge clk) begin
      #2;
      pixel_address = sweep ? pixel_address + 10'd1 : hold_addr;
   end

   // ---------------- stimulus ----------------
   logic [7:0] frame_buf [1024];
   logic [7:0] t4_last;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer bytes first..last; in_valid asserted with probability pct percent.
   task automatic send(input int first, input int last, input int pct);
      int idx   = first;
      int guard = 0;
      while (idx <= last) begin
         in_valid = ($urandom_range(99) < pct);
         in_data  = frame_buf[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         guard++;
         if (guard > 20000) begin
            chk("send_timeout", idx, last + 1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_swap(input string nm);
      int n    = 0;
      bit seen = 0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         seen = (frame_swapped === 1'b1);
         n++;
      end
      chk(nm, seen, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; rst_b_n = 1'b0;
      in_valid = 1'b0; in_data = '0; clear_req = 1'b0; clear_value = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; rst_b_n = 1'b1;

      // Reset fill: busy for exactly 2048 cycles, then ready.
      n = 0;
      while (1) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n > 3000) break;
      end
      chk("fill_cycles", n, 2048);
      chk("ready_after_fill", in_ready, 1);
      @(posedge clk); #1;

      // Ramp frame with in_valid held high.
      for (int i = 0; i < 1024; i++) frame_buf[i] = 8'(i);
      swap_cnt = 0;
      send(0, 1023, 100);
      @(negedge clk);
      chk("ready_drop", in_ready, 0);
      @(posedge clk); #1;
      wait_swap("ramp_swap");
      cyc(10);
      chk("ramp_swap_once", swap_cnt, 1);
      sweep = 1'b0;
      hold_addr = 10'd5;    cyc(3); @(negedge clk); chk("ramp_addr5", pixel_data, 8'h05);
      @(posedge clk); #1;
      hold_addr = 10'd1023; cyc(3); @(negedge clk); chk("ramp_addr1023", pixel_data, 8'hFF);
      @(posedge clk); #1;

      // Clear beats a simultaneous data beat.
      clear_req = 1'b1; clear_value = 8'hAA; in_valid = 1'b1; in_data = 8'h11;
      @(negedge clk);
      chk("clear_blocks_ready", in_ready, 0);
      @(posedge clk); #1;
      clear_req = 1'b0; in_valid = 1'b0;
      n = 0;
      repeat (1024) begin @(negedge clk); if (busy) n++; end
      chk("clear_busy", n, 1024);
      @(posedge clk); #1;
      sweep = 1'b1;
      wait_swap("clear_swap");
      sweep = 1'b0;
      for (int k = 0; k < 6; k++) begin
         hold_addr = (k == 0) ? 10'd0 : (k == 1) ? 10'd1023 : 10'($urandom_range(1023));
         cyc(3); @(negedge clk);
         chk("clear_data", pixel_data, 8'hAA);
         @(posedge clk); #1;
      end

      // Partial frame survives two wraps without swapping.
      for (int i = 0; i < 1024; i++) frame_buf[i] = 8'($urandom);
      t4_last = frame_buf[1023];
      send(0, 299, 100);
      sweep = 1'b1; swap_cnt = 0;
      cyc(2200);
      chk("partial_no_swap", swap_cnt, 0);
      @(negedge clk);
      chk("partial_ready", in_ready, 1);
      @(posedge clk); #1;
      send(300, 1023, 100);
      wait_swap("partial_swap");

      // Random valid gaps with a flat 0x3C frame.
      sweep = 1'b0; hold_addr = 10'd100;
      for (int i = 0; i < 1024; i++) frame_buf[i] = 8'h3C;
      hs_cnt = 0;
      send(0, 1023, 50);
      cyc(2);
      chk("handshakes", hs_cnt, 1024);

      // Reset the no-fill instance while it waits for a swap.
      rst_b_n = 1'b0;
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      @(negedge clk);
      chk("b_ready_after_rst", in_ready_b, 1);
      chk("b_busy_after_rst",  busy_b, 0);
      chk("b_pixel_after_rst", pixel_data_b, 8'h00);
      chk("b_swap_after_rst",  frame_swapped_b, 0);
      @(negedge clk);
      chk("b_front_zero", pixel_data_b, 8'h3C);

      // Old frame up to the wrap; new frame from the wrap-cycle read onwards.
      @(posedge clk); #1;
      hold_addr = 10'd1023; cyc(3); @(negedge clk);
      chk("pre_wrap_old", pixel_data, t4_last);
      @(posedge clk); #1;
      hold_addr = 10'd0;
      @(posedge clk);
      @(negedge clk);
      chk("wrap_new_data", pixel_data, 8'h3C);
      chk("wrap_pulse", frame_swapped, 1);
      chk("b_no_swap", frame_swapped_b, 0);
      cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
